// File: rtl/demod_segment_collector_pkg.sv
// Shared definitions for the demodulation segment collector: widths,
// FSM state encodings, Q16.16 constants and the sample-bank control word.
package demod_segment_collector_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_SEG = 10;
  localparam int IDX_W   = $clog2(NUM_SEG);

  // FSM state encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  // Q16.16 constants shared with the downstream correlator/threshold stage
  localparam logic [DATA_W-1:0] Q_ONE    = 32'h0001_0000;
  localparam logic [DATA_W-1:0] Q_MONE   = 32'hFFFF_0000;
  localparam logic [DATA_W-1:0] Q_THRESH = 32'h1000_0000;

  typedef logic [DATA_W-1:0] sample_t;

  // Control word from the FSM to the sample bank
  typedef struct packed {
    logic             we;      // write wdata into collect slot idx
    logic [IDX_W-1:0] idx;     // collect slot being written
    logic             xfer;    // copy collect bank to the output bank
    logic             direct;  // last output slot takes wdata instead of the bank
  } bank_ctrl_t;

endpackage

// File: rtl/demod_segment_collector_if.sv
// Serial sample stream into the segment collector (valid/ready handshake).
interface demod_segment_collector_if
  import demod_segment_collector_pkg::*;
  ();

  sample_t in_data;
  logic    in_valid;
  logic    in_sof;
  logic    in_ready;

  modport master (
    output in_data,
    output in_valid,
    output in_sof,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_sof,
    output in_ready
  );

endinterface

// File: rtl/demod_segment_collector_sample_bank.sv
// NUM_SEG x DATA_W collect bank with an indexed write port, plus a separate
// output bank that is loaded in parallel from the collect bank on transfer.
module demod_segment_collector_sample_bank
  import demod_segment_collector_pkg::*;
  (
    input  logic       clk,
    input  logic       reset,
    input  bank_ctrl_t ctrl,
    input  sample_t    wdata,
    output sample_t    seg [NUM_SEG]
  );

  sample_t bank_reg  [NUM_SEG];
  sample_t bank_next [NUM_SEG];
  sample_t seg_reg   [NUM_SEG];
  sample_t seg_next  [NUM_SEG];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_slot
      assign bank_next[gi] = (ctrl.we && (ctrl.idx == IDX_W'(gi))) ? wdata : bank_reg[gi];

      if (gi == NUM_SEG - 1) begin : g_last
        // The final sample can bypass the collect bank when it completes a frame
        assign seg_next[gi] = ctrl.xfer ? (ctrl.direct ? wdata : bank_reg[gi]) : seg_reg[gi];
      end else begin : g_body
        assign seg_next[gi] = ctrl.xfer ? bank_reg[gi] : seg_reg[gi];
      end

      assign seg[gi] = seg_reg[gi];
    end
  endgenerate

  // Register both banks; reset clears every slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        bank_reg[i] <= '0;
        seg_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SEG; i++) begin
        bank_reg[i] <= bank_next[i];
        seg_reg[i]  <= seg_next[i];
      end
    end
  end

endmodule

// File: rtl/demod_segment_collector.sv
// Collects a serial Q16.16 stream into NUM_SEG parallel segments, framed by
// in_sof, and hands complete frames downstream with a one-cycle start pulse.
// A full frame waits in the collect bank while ds_busy is high.
module demod_segment_collector
  import demod_segment_collector_pkg::*;
  #(
    parameter int FCNT_W = 16,
    parameter int DCNT_W = 8
  )
  (
    input  logic                      clk,
    input  logic                      reset,
    demod_segment_collector_if.slave  in_if,
    input  logic                      ds_busy,
    output sample_t                   segment_0,
    output sample_t                   segment_1,
    output sample_t                   segment_2,
    output sample_t                   segment_3,
    output sample_t                   segment_4,
    output sample_t                   segment_5,
    output sample_t                   segment_6,
    output sample_t                   segment_7,
    output sample_t                   segment_8,
    output sample_t                   segment_9,
    output logic                      start,
    output logic [FCNT_W-1:0]         frame_cnt,
    output logic [DCNT_W-1:0]         drop_cnt
  );

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

  logic [1:0]        state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              start_reg;
  logic [FCNT_W-1:0] frame_cnt_reg;
  logic [DCNT_W-1:0] drop_cnt_reg;
  logic              drop_inc;
  logic              accept;
  bank_ctrl_t        ctrl;
  sample_t           seg [NUM_SEG];

  assign in_if.in_ready = (state_reg != ST_FULL);
  assign accept         = in_if.in_valid & in_if.in_ready;

  // Next-state, index and bank control decode
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ctrl       = '0;
    ctrl.idx   = idx_reg;
    drop_inc   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Non-sof samples outside a frame are dropped silently
        if (accept && in_if.in_sof) begin
          ctrl.we    = 1'b1;
          ctrl.idx   = '0;
          idx_next   = IDX_W'(1);
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept) begin
          if (in_if.in_sof) begin
            // Resync: the partial frame is discarded even at the last slot
            drop_inc = 1'b1;
            ctrl.we  = 1'b1;
            ctrl.idx = '0;
            idx_next = IDX_W'(1);
          end else if (idx_reg != LAST_IDX) begin
            ctrl.we  = 1'b1;
            idx_next = idx_reg + IDX_W'(1);
          end else if (!ds_busy) begin
            ctrl.xfer   = 1'b1;
            ctrl.direct = 1'b1;
            idx_next    = '0;
            state_next  = ST_IDLE;
          end else begin
            ctrl.we    = 1'b1;
            state_next = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (!ds_busy) begin
          ctrl.xfer  = 1'b1;
          idx_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state, index, start pulse and the two counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      start_reg     <= 1'b0;
      frame_cnt_reg <= '0;
      drop_cnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      start_reg <= ctrl.xfer;
      if (ctrl.xfer) begin
        frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
      end
      if (drop_inc && (drop_cnt_reg != {DCNT_W{1'b1}})) begin
        drop_cnt_reg <= drop_cnt_reg + DCNT_W'(1);
      end
    end
  end

  demod_segment_collector_sample_bank u_bank (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl),
    .wdata (in_if.in_data),
    .seg   (seg)
  );

  assign segment_0 = seg[0];
  assign segment_1 = seg[1];
  assign segment_2 = seg[2];
  assign segment_3 = seg[3];
  assign segment_4 = seg[4];
  assign segment_5 = seg[5];
  assign segment_6 = seg[6];
  assign segment_7 = seg[7];
  assign segment_8 = seg[8];
  assign segment_9 = seg[9];

  assign start     = start_reg;
  assign frame_cnt = frame_cnt_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_demod_segment_collector.sv
// Directed bench for demod_segment_collector: a per-cycle vector table for
// nominal, backpressure and resync traffic, plus hand sequences for reset,
// saturation and frame-counter wrap (second instance with FCNT_W=4).
module tb_demod_segment_collector;
  import demod_segment_collector_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ds_busy = 1'b0;

  always #5 clk = ~clk;

  demod_segment_collector_if bus ();
  demod_segment_collector_if bus_w ();

  assign bus_w.in_data  = bus.in_data;
  assign bus_w.in_valid = bus.in_valid;
  assign bus_w.in_sof   = bus.in_sof;

  sample_t     seg  [NUM_SEG];
  sample_t     segw [NUM_SEG];
  logic        start, start_w;
  logic [15:0] fcnt;
  logic [3:0]  fcnt_w;
  logic [7:0]  dcnt, dcnt_w;

  demod_segment_collector dut (
    .clk(clk), .reset(reset), .in_if(bus.slave), .ds_busy(ds_busy),
    .segment_0(seg[0]), .segment_1(seg[1]), .segment_2(seg[2]), .segment_3(seg[3]),
    .segment_4(seg[4]), .segment_5(seg[5]), .segment_6(seg[6]), .segment_7(seg[7]),
    .segment_8(seg[8]), .segment_9(seg[9]),
    .start(start), .frame_cnt(fcnt), .drop_cnt(dcnt)
  );

  demod_segment_collector #(.FCNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .in_if(bus_w.slave), .ds_busy(ds_busy),
    .segment_0(segw[0]), .segment_1(segw[1]), .segment_2(segw[2]), .segment_3(segw[3]),
    .segment_4(segw[4]), .segment_5(segw[5]), .segment_6(segw[6]), .segment_7(segw[7]),
    .segment_8(segw[8]), .segment_9(segw[9]),
    .start(start_w), .frame_cnt(fcnt_w), .drop_cnt(dcnt_w)
  );

  typedef struct {
    logic        v;
    logic        sof;
    sample_t     d;
    logic        busy;
    logic        st;
    logic        rdy;
    logic [15:0] fc;
    logic [7:0]  dc;
    sample_t     s0;
    sample_t     s9;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_start = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic sof, input sample_t d, input logic busy,
                     input logic st, input logic rdy, input logic [15:0] fc,
                     input logic [7:0] dc, input sample_t s0, input sample_t s9);
    vec_t r;
    r.v = v; r.sof = sof; r.d = d; r.busy = busy; r.st = st; r.rdy = rdy;
    r.fc = fc; r.dc = dc; r.s0 = s0; r.s9 = s9;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic v, input logic sof, input sample_t d, input logic busy);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = d;
    ds_busy      = busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_segs(input string name, input sample_t base, input logic cst);
    for (int k = 0; k < NUM_SEG; k++) begin
      chk($sformatf("%s seg%0d", name, k), seg[k], cst ? base : base + sample_t'(k));
      chk($sformatf("%s segw%0d", name, k), segw[k], cst ? base : base + sample_t'(k));
    end
  endtask

  // Ten back-to-back accepts with ds_busy low; start must appear only after the last one
  task automatic send_frame(input string name, input sample_t base, input logic cst);
    for (int k = 0; k < NUM_SEG; k++) begin
      drive(1'b1, k == 0, cst ? base : base + sample_t'(k), 1'b0);
      tick();
      chk($sformatf("%s start k%0d", name, k), start, k == NUM_SEG - 1);
    end
    if (last_start >= 0) chk($sformatf("%s pulse gap", name), 64'(cyc - last_start), 64'd10);
    last_start = cyc;
    $display("frame %s: base=%h start at cycle %0d frame_cnt=%0d", name, base, cyc, fcnt);
  endtask

  initial begin
    sample_t b0, b9, d0, d9;
    drive(1'b0, 1'b0, '0, 1'b0);

    // Reset state
    tick(); tick();
    chk("rst start", start, 1'b0);
    chk("rst ready", bus.in_ready, 1'b1);
    chk("rst fcnt", fcnt, 16'd0);
    chk("rst dcnt", dcnt, 8'd0);
    check_segs("rst", '0, 1'b1);
    reset = 1'b1;

    // Nominal frame
    for (int k = 0; k < 10; k++)
      add(1, k == 0, sample_t'(k + 1) * Q_ONE, 0, k == 9, 1, (k == 9) ? 16'd1 : 16'd0, 0,
          (k == 9) ? 32'h0001_0000 : 32'h0, (k == 9) ? 32'h000A_0000 : 32'h0);
    // Backpressure: busy at the 10th accept, held for five cycles in total
    b0 = 32'h0100_0000; b9 = 32'h0100_0009;
    for (int k = 0; k < 10; k++)
      add(1, k == 0, b0 + sample_t'(k), k == 9, 0, k != 9, 1, 0, 32'h0001_0000, 32'h000A_0000);
    for (int k = 0; k < 4; k++)
      add(1, 1, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 32'h0001_0000, 32'h000A_0000);
    add(1, 1, 32'hDEAD_BEEF, 0, 1, 1, 2, 0, b0, b9);
    add(0, 0, 32'h0, 0, 0, 1, 2, 0, b0, b9);
    // Resync on the 6th sample; busy on mid-frame accepts has no effect
    for (int k = 0; k < 5; k++)
      add(1, k == 0, 32'h0C00_0000 + sample_t'(k), 0, 0, 1, 2, 0, b0, b9);
    d0 = 32'hD000_0000; d9 = 32'hD000_0009;
    for (int k = 0; k < 10; k++)
      add(1, k == 0, d0 + sample_t'(k), (k == 3) || (k == 4), k == 9, 1,
          (k == 9) ? 16'd3 : 16'd2, 1, (k == 9) ? d0 : b0, (k == 9) ? d9 : b9);
    // Restart with sof at the final slot
    for (int k = 0; k < 9; k++)
      add(1, k == 0, 32'h0E00_0000 + sample_t'(k), 0, 0, 1, 3, 1, d0, d9);
    for (int k = 0; k < 10; k++)
      add(1, k == 0, 32'hF000_0000 + sample_t'(k), 0, k == 9, 1,
          (k == 9) ? 16'd4 : 16'd3, 2, (k == 9) ? 32'hF000_0000 : d0, (k == 9) ? 32'hF000_0009 : d9);
    // Idle junk, busy high in IDLE
    for (int k = 0; k < 4; k++)
      add(1, 0, 32'h1234_5678, 1, 0, 1, 4, 2, 32'hF000_0000, 32'hF000_0009);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].busy);
      tick();
      chk($sformatf("v%0d start", i), start, tbl[i].st);
      chk($sformatf("v%0d ready", i), bus.in_ready, tbl[i].rdy);
      chk($sformatf("v%0d fcnt", i), fcnt, tbl[i].fc);
      chk($sformatf("v%0d dcnt", i), dcnt, tbl[i].dc);
      chk($sformatf("v%0d seg0", i), seg[0], tbl[i].s0);
      chk($sformatf("v%0d seg9", i), seg[9], tbl[i].s9);
      chk($sformatf("v%0d start_w", i), start_w, tbl[i].st);
      chk($sformatf("v%0d fcnt_w", i), fcnt_w, tbl[i].fc[3:0]);
      $display("vec %0d: v=%0b sof=%0b d=%h busy=%0b -> start=%0b ready=%0b fcnt=%0d dcnt=%0d",
               i, tbl[i].v, tbl[i].sof, tbl[i].d, tbl[i].busy, start, bus.in_ready, fcnt, dcnt);
    end
    check_segs("frameF", 32'hF000_0000, 1'b0);

    // Mid-frame reset with traffic running
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k == 0, 32'h0600_0000 + sample_t'(k), 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h0600_0004, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("arst start", start, 1'b0);
    chk("arst fcnt", fcnt, 16'd0);
    chk("arst dcnt", dcnt, 8'd0);
    chk("arst ready", bus.in_ready, 1'b1);
    check_segs("arst", '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k == 1, 32'h0700_0000, 1'b0);
      tick();
      chk("rst hold start", start, 1'b0);
    end
    reset = 1'b1;
    $display("reset released at cycle %0d", cyc);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b0, 32'h0800_0000 + sample_t'(k), 1'b0);
      tick();
      chk("post rst start", start, 1'b0);
    end
    chk("post rst fcnt", fcnt, 16'd0);
    chk("post rst dcnt", dcnt, 8'd0);
    send_frame("mone", Q_MONE, 1'b1);
    check_segs("mone", Q_MONE, 1'b1);
    chk("mone fcnt", fcnt, 16'd1);
    chk("mone dcnt", dcnt, 8'd0);

    // drop_cnt saturation: one opening sof then 256 restarts
    drive(1'b1, 1'b1, Q_THRESH, 1'b0);
    tick();
    for (int k = 1; k <= 256; k++) begin
      drive(1'b1, 1'b1, Q_THRESH + sample_t'(k), 1'b0);
      tick();
      if (k == 254) chk("dcnt 254", dcnt, 8'd254);
      if (k == 255) chk("dcnt 255", dcnt, 8'd255);
    end
    chk("dcnt sat", dcnt, 8'd255);
    chk("dcnt_w sat", dcnt_w, 8'd255);
    $display("restarts done: dcnt=%0d", dcnt);
    for (int k = 1; k < NUM_SEG; k++) begin
      drive(1'b1, 1'b0, 32'h0900_0000 + sample_t'(k), 1'b0);
      tick();
      chk("sat frame start", start, k == NUM_SEG - 1);
    end
    chk("sat frame seg0", seg[0], Q_THRESH + 32'd256);
    chk("sat frame seg9", seg[9], 32'h0900_0009);
    chk("sat frame fcnt", fcnt, 16'd2);
    last_start = cyc;

    // Back-to-back frames up to 16 in total; narrow counter wraps to 0
    for (int f = 0; f < 14; f++)
      send_frame($sformatf("b2b%0d", f), 32'h4000_0000 + (sample_t'(f) << 8), 1'b0);
    chk("wrap fcnt", fcnt, 16'd16);
    chk("wrap fcnt_w", fcnt_w, 4'd0);
    check_segs("b2b13", 32'h4000_0D00, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    tick();
    chk("final start", start, 1'b0);
    chk("final dcnt", dcnt, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
